// File: rtl/pool_pkg.sv
// Shared types, constants and helpers for the 2x2 max-pool stage.
package pool_pkg;

    localparam int DATA_W    = 32;
    localparam int LANE_W    = 8;
    localparam int DIM_W     = 8;
    localparam int NUM_LANES = DATA_W / LANE_W;

    // Word pointers cover the full 32-bit byte address space.
    localparam int PTR_W = 30;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        RD3,
        WR,
        DONE
    } state_t;

    // Word index to byte address.
    function automatic logic [31:0] word2byte(input logic [PTR_W-1:0] addr);
        return {addr[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/pool_2x2_lane_max4.sv
// Lane-wise signed maximum of two packed words with optional ReLU clamp.
// Purely combinational; the top shares one instance across all merge steps.
module lane_max4 #(
    parameter int DATA_W = 32,
    parameter int LANE_W = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              relu_i,
    output logic [DATA_W-1:0] y_o
);

    localparam int NL = DATA_W / LANE_W;

    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
        logic signed [LANE_W-1:0] lane_a;
        logic signed [LANE_W-1:0] lane_b;
        logic signed [LANE_W-1:0] lane_max;

        assign lane_a   = a_i[gi*LANE_W +: LANE_W];
        assign lane_b   = b_i[gi*LANE_W +: LANE_W];
        // Both operands are signed, so -128 correctly loses to everything.
        assign lane_max = (lane_a > lane_b) ? lane_a : lane_b;
        // A negative maximum is clamped to zero when ReLU is requested.
        assign y_o[gi*LANE_W +: LANE_W] = (relu_i && lane_max[LANE_W-1]) ? '0 : lane_max;
    end

endmodule

// File: rtl/pool_2x2.sv
// 2x2 / stride-2 max-pool over a conv output BRAM, one output word every
// five cycles. Source reads use a 1-cycle-latency BRAM; the four reads of
// a window are merged into a per-lane running max and the result is
// written to the destination BRAM with a single-cycle strobe.
module pool_2x2
    import pool_pkg::*;
#(
    parameter int DATA_W = pool_pkg::DATA_W,
    parameter int LANE_W = pool_pkg::LANE_W,
    parameter int DIM_W  = pool_pkg::DIM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              finish,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_height,
    input  logic [DIM_W-1:0]  cfg_groups,
    input  logic              cfg_relu,
    input  logic [31:0]       cfg_src_base,
    input  logic [31:0]       cfg_dst_base,
    output logic              Msrc_en,
    output logic [31:0]       Msrc_addr,
    input  logic [DATA_W-1:0] Msrc_R_data,
    output logic              Mdst_en,
    output logic [31:0]       Mdst_addr,
    output logic [3:0]        Mdst_W_req,
    output logic [DATA_W-1:0] Mdst_W_data
);

    localparam logic [DIM_W-1:0] ONE_D = DIM_W'(1);
    localparam logic [DIM_W-1:0] TWO_D = DIM_W'(2);
    localparam logic [PTR_W-1:0] ONE_P = PTR_W'(1);
    localparam logic [PTR_W-1:0] TWO_P = PTR_W'(2);

    state_t            state_q;
    logic              start_q;
    logic              finish_q;

    // Frame configuration captured at launch.
    logic [DIM_W-1:0]  w_q;
    logic [DIM_W-1:0]  ow_q;
    logic [DIM_W-1:0]  oh_q;
    logic [DIM_W-1:0]  g_q;
    logic              h_odd_q;
    logic              relu_q;

    // Output-window position.
    logic [DIM_W-1:0]  ox_q;
    logic [DIM_W-1:0]  oy_q;
    logic [DIM_W-1:0]  gc_q;

    // Word pointers: row_q = (g, 2oy, 0), pix_q = (g, 2oy, 2ox), dst_q = next output word.
    logic [PTR_W-1:0]  row_q;
    logic [PTR_W-1:0]  pix_q;
    logic [PTR_W-1:0]  dst_q;

    logic [31:0]       msrc_addr_q;
    logic [31:0]       mdst_addr_q;
    logic [3:0]        mdst_req_q;
    logic [DATA_W-1:0] mdst_data_q;
    logic [DATA_W-1:0] max_q;

    logic [DIM_W-1:0]  ox_d;
    logic [DIM_W-1:0]  oy_d;
    logic [DIM_W-1:0]  gc_d;
    logic [PTR_W-1:0]  row_d;
    logic [PTR_W-1:0]  pix_d;

    logic [PTR_W-1:0]  w_ext;
    logic [PTR_W-1:0]  w2_ext;
    logic              last_ox;
    logic              last_oy;
    logic              last_g;
    logic              launch;
    logic              launch_empty;
    logic              relu_now;
    logic [DATA_W-1:0] lane_max;
    logic              unused_addr_lsbs;

    // Byte-offset bits of the bases are ignored; the BRAMs are word-addressed.
    assign unused_addr_lsbs = ^{cfg_src_base[1:0], cfg_dst_base[1:0]};

    assign w_ext  = PTR_W'(w_q);
    assign w2_ext = {w_ext[PTR_W-2:0], 1'b0};

    assign last_ox = (ox_q == ow_q - ONE_D);
    assign last_oy = (oy_q == oh_q - ONE_D);
    assign last_g  = (gc_q == g_q - ONE_D);

    assign launch       = (state_q == IDLE) && start && !start_q;
    assign launch_empty = (cfg_width < TWO_D) || (cfg_height < TWO_D) || (cfg_groups == '0);

    // ReLU only applies to the final merge; intermediate merges keep signs.
    assign relu_now = relu_q && (state_q == WR);

    lane_max4 #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_lane_max (
        .a_i    (max_q),
        .b_i    (Msrc_R_data),
        .relu_i (relu_now),
        .y_o    (lane_max)
    );

    // Next window position and pointers, stepping with adders only.
    always_comb begin
        ox_d  = ox_q;
        oy_d  = oy_q;
        gc_d  = gc_q;
        row_d = row_q;
        pix_d = pix_q;
        if (!last_ox) begin
            ox_d  = ox_q + ONE_D;
            pix_d = pix_q + TWO_P;
        end else begin
            ox_d = '0;
            if (!last_oy) begin
                oy_d  = oy_q + ONE_D;
                row_d = row_q + w2_ext;
            end else begin
                // Skip the dropped odd last row to reach the next plane.
                oy_d  = '0;
                gc_d  = gc_q + ONE_D;
                row_d = row_q + w2_ext + (h_odd_q ? w_ext : '0);
            end
            pix_d = row_d;
        end
    end

    // Frame sequencer with registered BRAM-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            finish_q    <= 1'b0;
            w_q         <= '0;
            ow_q        <= '0;
            oh_q        <= '0;
            g_q         <= '0;
            h_odd_q     <= 1'b0;
            relu_q      <= 1'b0;
            ox_q        <= '0;
            oy_q        <= '0;
            gc_q        <= '0;
            row_q       <= '0;
            pix_q       <= '0;
            dst_q       <= '0;
            msrc_addr_q <= '0;
            mdst_addr_q <= '0;
            mdst_req_q  <= '0;
            mdst_data_q <= '0;
            max_q       <= '0;
        end else begin
            start_q    <= start;
            mdst_req_q <= 4'h0;
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        w_q     <= cfg_width;
                        ow_q    <= cfg_width >> 1;
                        oh_q    <= cfg_height >> 1;
                        g_q     <= cfg_groups;
                        h_odd_q <= cfg_height[0];
                        relu_q  <= cfg_relu;
                        ox_q    <= '0;
                        oy_q    <= '0;
                        gc_q    <= '0;
                        if (launch_empty) begin
                            state_q  <= DONE;
                            finish_q <= 1'b1;
                        end else begin
                            state_q     <= RD0;
                            row_q       <= cfg_src_base[31:2];
                            pix_q       <= cfg_src_base[31:2];
                            dst_q       <= cfg_dst_base[31:2];
                            msrc_addr_q <= word2byte(cfg_src_base[31:2]);
                        end
                    end
                end
                RD0: begin
                    msrc_addr_q <= word2byte(pix_q + ONE_P);
                    state_q     <= RD1;
                end
                RD1: begin
                    max_q       <= Msrc_R_data;
                    msrc_addr_q <= word2byte(pix_q + w_ext);
                    state_q     <= RD2;
                end
                RD2: begin
                    max_q       <= lane_max;
                    msrc_addr_q <= word2byte(pix_q + w_ext + ONE_P);
                    state_q     <= RD3;
                end
                RD3: begin
                    max_q   <= lane_max;
                    state_q <= WR;
                end
                WR: begin
                    mdst_data_q <= lane_max;
                    mdst_addr_q <= word2byte(dst_q);
                    mdst_req_q  <= 4'hF;
                    dst_q       <= dst_q + ONE_P;
                    if (last_ox && last_oy && last_g) begin
                        state_q  <= DONE;
                        finish_q <= 1'b1;
                    end else begin
                        ox_q        <= ox_d;
                        oy_q        <= oy_d;
                        gc_q        <= gc_d;
                        row_q       <= row_d;
                        pix_q       <= pix_d;
                        msrc_addr_q <= word2byte(pix_d);
                        state_q     <= RD0;
                    end
                end
                DONE: begin
                    if (!start) begin
                        finish_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign finish      = finish_q;
    assign Msrc_en     = 1'b1;
    assign Msrc_addr   = msrc_addr_q;
    assign Mdst_en     = 1'b1;
    assign Mdst_addr   = mdst_addr_q;
    assign Mdst_W_req  = mdst_req_q;
    assign Mdst_W_data = mdst_data_q;

endmodule

// File: tb/tb_pool_2x2.sv
// Directed bench for pool_2x2: source BRAM model, destination write monitor,
// one task per scenario with hand-computed expected words and timings.
module tb_pool_2x2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        finish;
    logic [7:0]  cfg_width;
    logic [7:0]  cfg_height;
    logic [7:0]  cfg_groups;
    logic        cfg_relu;
    logic [31:0] cfg_src_base;
    logic [31:0] cfg_dst_base;
    logic        Msrc_en;
    logic [31:0] Msrc_addr;
    logic [31:0] Msrc_R_data;
    logic        Mdst_en;
    logic [31:0] Mdst_addr;
    logic [3:0]  Mdst_W_req;
    logic [31:0] Mdst_W_data;

    int errors = 0;
    int checks = 0;

    logic [31:0] src_mem [0:255];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          bad_req = 0;
    int          forbid_reads = 0;
    logic        chk_forbid = 1'b0;

    always #5 clk = ~clk;

    pool_2x2 dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .finish       (finish),
        .cfg_width    (cfg_width),
        .cfg_height   (cfg_height),
        .cfg_groups   (cfg_groups),
        .cfg_relu     (cfg_relu),
        .cfg_src_base (cfg_src_base),
        .cfg_dst_base (cfg_dst_base),
        .Msrc_en      (Msrc_en),
        .Msrc_addr    (Msrc_addr),
        .Msrc_R_data  (Msrc_R_data),
        .Mdst_en      (Mdst_en),
        .Mdst_addr    (Mdst_addr),
        .Mdst_W_req   (Mdst_W_req),
        .Mdst_W_data  (Mdst_W_data)
    );

    // Source BRAM: address sampled at the edge, data one cycle later.
    always @(posedge clk) Msrc_R_data <= src_mem[Msrc_addr[9:2]];

    // Destination monitor plus the odd-dimension read filter (plane base 0x100, W=5, H=3).
    always @(negedge clk) begin
        if (Mdst_W_req == 4'hF) begin
            wr_addr_q.push_back(Mdst_addr);
            wr_data_q.push_back(Mdst_W_data);
        end else if (Mdst_W_req != 4'h0) begin
            bad_req++;
        end
        if (chk_forbid) begin
            int idx;
            idx = int'(Msrc_addr[31:2]) - 'h40;
            if (idx >= 0 && idx < 30 && (((idx % 15) / 5) == 2 || ((idx % 15) % 5) == 4))
                forbid_reads++;
        end
    end

    task automatic run_frame(input logic [7:0] w, input logic [7:0] h, input logic [7:0] g,
                             input logic relu, input logic [31:0] sb, input logic [31:0] db,
                             output int cyc);
        @(negedge clk);
        cfg_width = w; cfg_height = h; cfg_groups = g; cfg_relu = relu;
        cfg_src_base = sb; cfg_dst_base = db;
        start = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            #1;
        end while (!finish && cyc < 500);
    endtask

    task automatic end_frame;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic fill_ramp4x4;
        logic [7:0] v;
        for (int i = 0; i < 256; i++) src_mem[i] = 32'h0;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++) begin
                v = 8'(y * 4 + x);
                src_mem[y*4+x] = {4{v}};
            end
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0;
        cfg_width = '0; cfg_height = '0; cfg_groups = '0; cfg_relu = 1'b0;
        cfg_src_base = '0; cfg_dst_base = '0;
        repeat (3) @(negedge clk);
        checks++; if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish: got %b expected 0", finish); end
        checks++; if (Msrc_addr !== 32'h0) begin errors++; $display("FAIL reset_msrc_addr: got %h expected 0", Msrc_addr); end
        checks++; if (Mdst_addr !== 32'h0) begin errors++; $display("FAIL reset_mdst_addr: got %h expected 0", Mdst_addr); end
        checks++; if (Mdst_W_req !== 4'h0) begin errors++; $display("FAIL reset_req: got %h expected 0", Mdst_W_req); end
        checks++; if (Mdst_W_data !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", Mdst_W_data); end
        checks++; if (Msrc_en !== 1'b1 || Mdst_en !== 1'b1) begin errors++; $display("FAIL reset_enables: got %b%b expected 11", Msrc_en, Mdst_en); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_basic;
        int cyc;
        logic [31:0] exp_d [4];
        logic [31:0] got_a, got_d;
        exp_d = '{32'h05050505, 32'h07070707, 32'h0D0D0D0D, 32'h0F0F0F0F};
        fill_ramp4x4();
        wr_addr_q.delete(); wr_data_q.delete();
        run_frame(8'd4, 8'd4, 8'd1, 1'b0, 32'h0, 32'h400, cyc);
        checks++; if (cyc != 21) begin errors++; $display("FAIL basic_latency: got %0d expected 21", cyc); end
        checks++; if (Mdst_W_req !== 4'hF) begin errors++; $display("FAIL basic_last_strobe_with_finish: got %h expected f", Mdst_W_req); end
        end_frame();
        checks++; if (wr_data_q.size() != 4) begin errors++; $display("FAIL basic_count: got %0d expected 4", wr_data_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got_a = (i < wr_addr_q.size()) ? wr_addr_q[i] : 32'hx;
            got_d = (i < wr_data_q.size()) ? wr_data_q[i] : 32'hx;
            $display("basic wr %0d addr=%h data=%h", i, got_a, got_d);
            checks++;
            if (got_a !== 32'h400 + 32'(4*i) || got_d !== exp_d[i]) begin
                errors++;
                $display("FAIL basic_word%0d: got %h@%h expected %h@%h", i, got_d, got_a, exp_d[i], 32'h400 + 32'(4*i));
            end
        end
    endtask

    task automatic test_signed_relu;
        int cyc;
        logic [31:0] got_d;
        logic [31:0] exp_d [2];
        exp_d = '{32'hFF8005FD, 32'h00000500};
        for (int i = 0; i < 256; i++) src_mem[i] = 32'h0;
        src_mem[0] = 32'hFB8003F9;   // {-5,-128,3,-7}
        src_mem[1] = 32'h8080059C;   // {-128,-128,5,-100}
        src_mem[2] = 32'hFE8080FD;   // {-2,-128,-128,-3}
        src_mem[3] = 32'hFF800480;   // {-1,-128,4,-128}
        for (int r = 0; r < 2; r++) begin
            wr_addr_q.delete(); wr_data_q.delete();
            run_frame(8'd2, 8'd2, 8'd1, r[0], 32'h0, 32'h200, cyc);
            checks++; if (cyc != 6) begin errors++; $display("FAIL signed_latency relu=%0d: got %0d expected 6", r, cyc); end
            end_frame();
            got_d = (wr_data_q.size() == 1) ? wr_data_q[0] : 32'hx;
            $display("signed relu=%0d wr count=%0d data=%h", r, wr_data_q.size(), got_d);
            checks++;
            if (got_d !== exp_d[r] || wr_addr_q.size() != 1 || wr_addr_q[0] !== 32'h200) begin
                errors++;
                $display("FAIL signed_word relu=%0d: got %h (count %0d) expected %h@200", r, got_d, wr_data_q.size(), exp_d[r]);
            end
        end
    endtask

    task automatic test_odd_dims;
        int cyc, idx;
        logic [7:0] v;
        logic [31:0] exp_d [4];
        logic [31:0] got_a, got_d;
        exp_d = '{32'h06060606, 32'h08080808, 32'h26262626, 32'h28282828};
        for (int i = 0; i < 256; i++) src_mem[i] = 32'h0;
        for (int g = 0; g < 2; g++)
            for (int y = 0; y < 3; y++)
                for (int x = 0; x < 5; x++) begin
                    idx = 'h40 + g*15 + y*5 + x;
                    v = (y == 2 || x == 4) ? 8'h7F : 8'(g*32 + y*5 + x);
                    src_mem[idx] = {4{v}};
                end
        wr_addr_q.delete(); wr_data_q.delete();
        forbid_reads = 0;
        chk_forbid = 1'b1;
        run_frame(8'd5, 8'd3, 8'd2, 1'b0, 32'h100, 32'h800, cyc);
        chk_forbid = 1'b0;
        checks++; if (cyc != 21) begin errors++; $display("FAIL odd_latency: got %0d expected 21", cyc); end
        end_frame();
        checks++; if (forbid_reads != 0) begin errors++; $display("FAIL odd_dropped_reads: got %0d expected 0", forbid_reads); end
        checks++; if (wr_data_q.size() != 4) begin errors++; $display("FAIL odd_count: got %0d expected 4", wr_data_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got_a = (i < wr_addr_q.size()) ? wr_addr_q[i] : 32'hx;
            got_d = (i < wr_data_q.size()) ? wr_data_q[i] : 32'hx;
            $display("odd wr %0d addr=%h data=%h", i, got_a, got_d);
            checks++;
            if (got_a !== 32'h800 + 32'(4*i) || got_d !== exp_d[i]) begin
                errors++;
                $display("FAIL odd_word%0d: got %h@%h expected %h@%h", i, got_d, got_a, exp_d[i], 32'h800 + 32'(4*i));
            end
        end
    endtask

    task automatic test_degenerate;
        int cyc;
        logic [31:0] addr_before;
        logic [7:0] dw [2];
        logic [7:0] dg [2];
        dw = '{8'd1, 8'd4};
        dg = '{8'd1, 8'd0};
        for (int k = 0; k < 2; k++) begin
            wr_addr_q.delete(); bad_req = 0;
            addr_before = Msrc_addr;
            run_frame(dw[k], 8'd4, dg[k], 1'b0, 32'h40, 32'h600, cyc);
            $display("degenerate W=%0d G=%0d finish after %0d cycles", dw[k], dg[k], cyc);
            checks++; if (cyc != 1) begin errors++; $display("FAIL degen%0d_latency: got %0d expected 1", k, cyc); end
            checks++; if (Msrc_addr !== addr_before) begin errors++; $display("FAIL degen%0d_msrc_addr: got %h expected %h", k, Msrc_addr, addr_before); end
            end_frame();
            checks++;
            if (wr_addr_q.size() != 0 || bad_req != 0) begin
                errors++;
                $display("FAIL degen%0d_writes: got %0d strobes (%0d partial) expected 0", k, wr_addr_q.size(), bad_req);
            end
        end
    endtask

    task automatic test_reset_midframe;
        int cyc;
        logic [31:0] exp_d [4];
        logic [31:0] got_d;
        exp_d = '{32'h05050505, 32'h07070707, 32'h0D0D0D0D, 32'h0F0F0F0F};
        fill_ramp4x4();
        wr_addr_q.delete(); wr_data_q.delete();
        @(negedge clk);
        cfg_width = 8'd4; cfg_height = 8'd4; cfg_groups = 8'd1; cfg_relu = 1'b0;
        cfg_src_base = 32'h0; cfg_dst_base = 32'h400;
        start = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++; if (Msrc_addr !== 32'h18) begin errors++; $display("FAIL midreset_rd2_addr: got %h expected 18", Msrc_addr); end
        rst = 1'b0; start = 1'b0;
        #1;
        $display("reset asserted mid-frame");
        checks++; if (Mdst_W_req !== 4'h0) begin errors++; $display("FAIL midreset_req: got %h expected 0", Mdst_W_req); end
        checks++; if (Msrc_addr !== 32'h0) begin errors++; $display("FAIL midreset_msrc_addr: got %h expected 0", Msrc_addr); end
        checks++; if (Mdst_addr !== 32'h0 || Mdst_W_data !== 32'h0) begin errors++; $display("FAIL midreset_dst: got %h/%h expected 0/0", Mdst_addr, Mdst_W_data); end
        checks++; if (finish !== 1'b0) begin errors++; $display("FAIL midreset_finish: got %b expected 0", finish); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        checks++; if (wr_data_q.size() != 1) begin errors++; $display("FAIL midreset_strobes: got %0d expected 1", wr_data_q.size()); end
        wr_addr_q.delete(); wr_data_q.delete();
        run_frame(8'd4, 8'd4, 8'd1, 1'b0, 32'h0, 32'h400, cyc);
        checks++; if (cyc != 21) begin errors++; $display("FAIL relaunch_latency: got %0d expected 21", cyc); end
        end_frame();
        checks++; if (wr_data_q.size() != 4) begin errors++; $display("FAIL relaunch_count: got %0d expected 4", wr_data_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got_d = (i < wr_data_q.size()) ? wr_data_q[i] : 32'hx;
            $display("relaunch wr %0d data=%h", i, got_d);
            checks++; if (got_d !== exp_d[i]) begin errors++; $display("FAIL relaunch_word%0d: got %h expected %h", i, got_d, exp_d[i]); end
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        logic [31:0] exp_d [4];
        logic [31:0] got_a, got_d;
        exp_d = '{32'h05050505, 32'h07070707, 32'h0D0D0D0D, 32'h0F0F0F0F};
        fill_ramp4x4();
        wr_addr_q.delete(); wr_data_q.delete();
        @(negedge clk);
        cfg_width = 8'd4; cfg_height = 8'd4; cfg_groups = 8'd1; cfg_relu = 1'b0;
        cfg_src_base = 32'h0; cfg_dst_base = 32'h400;
        start = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == 6) start = 1'b0;
            if (cyc == 8) start = 1'b1;
            // Changing cfg mid-frame must not matter.
            if (cyc == 10) cfg_width = 8'd2;
        end while (!finish && cyc < 500);
        checks++; if (cyc != 21) begin errors++; $display("FAIL hs_latency: got %0d expected 21", cyc); end
        repeat (5) @(negedge clk);
        checks++; if (finish !== 1'b1) begin errors++; $display("FAIL hs_finish_hold: got %b expected 1", finish); end
        start = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (finish !== 1'b0) begin errors++; $display("FAIL hs_finish_drop: got %b expected 0", finish); end
        repeat (2) @(negedge clk);
        cfg_width = 8'd4;
        run_frame(8'd4, 8'd4, 8'd1, 1'b0, 32'h0, 32'h400, cyc);
        checks++; if (cyc != 21) begin errors++; $display("FAIL hs_second_latency: got %0d expected 21", cyc); end
        end_frame();
        checks++; if (wr_data_q.size() != 8) begin errors++; $display("FAIL hs_count: got %0d expected 8", wr_data_q.size()); end
        for (int i = 0; i < 8; i++) begin
            got_a = (i < wr_addr_q.size()) ? wr_addr_q[i] : 32'hx;
            got_d = (i < wr_data_q.size()) ? wr_data_q[i] : 32'hx;
            $display("b2b wr %0d addr=%h data=%h", i, got_a, got_d);
            checks++;
            if (got_a !== 32'h400 + 32'(4*(i%4)) || got_d !== exp_d[i%4]) begin
                errors++;
                $display("FAIL hs_word%0d: got %h@%h expected %h@%h", i, got_d, got_a, exp_d[i%4], 32'h400 + 32'(4*(i%4)));
            end
        end
        checks++; if (bad_req != 0) begin errors++; $display("FAIL partial_strobes: got %0d expected 0", bad_req); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed_relu();
        test_odd_dims();
        test_degenerate();
        test_reset_midframe();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
